// File: rtl/noc_credit_valrdy_mc.sv
// Multi-channel credit (valid/yummy) to valid/ready converter with per-channel FIFOs.
// Optional zero-latency bypass when NOC_CRDT_VALRDY_BYPASS_EN is defined.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module noc_credit_valrdy_mc #(
    parameter int unsigned DATA_WIDTH = `NOC_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            valid_in,
    output logic [NUM_CH-1:0]            yummy_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            valid_out,
    input  logic [NUM_CH-1:0]            ready_out,
    output logic [NUM_CH*CNT_W-1:0]      level_o,
    output logic [NUM_CH-1:0]            overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] mem_d [DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      count_q, count_d;
        logic                  ovf_q, ovf_d;
        logic                  yummy_q, yummy_d;
        logic [DATA_WIDTH-1:0] din;
        logic [DATA_WIDTH-1:0] head;
        logic                  empty, full, vout, pop, deq, push;

        assign din   = data_in[c*DATA_WIDTH +: DATA_WIDTH];
        assign empty = (count_q == '0);
        assign full  = (count_q == CNT_W'(DEPTH));
        assign head  = mem_q[rd_ptr_q];

`ifdef NOC_CRDT_VALRDY_BYPASS_EN
        // An empty channel forwards the incoming flit in the same cycle.
        assign vout = !empty || valid_in[c];
        assign data_out[c*DATA_WIDTH +: DATA_WIDTH] =
            !empty ? head : (valid_in[c] ? din : '0);
`else
        assign vout = !empty;
        assign data_out[c*DATA_WIDTH +: DATA_WIDTH] = empty ? '0 : head;
`endif

        // pop includes a bypassed flit; deq only counts flits leaving storage.
        assign pop  = vout && ready_out[c];
        assign deq  = pop && !empty;
        assign push = valid_in[c] && (!full || deq) && !(empty && pop);

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            ovf_d    = ovf_q || (valid_in[c] && full && !deq);
            yummy_d  = pop;
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem_q[i] <= '0;
                end
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
                yummy_q  <= 1'b0;
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                ovf_q    <= ovf_d;
                yummy_q  <= yummy_d;
            end
        end

        assign valid_out[c]                = vout;
        assign yummy_in[c]                 = yummy_q;
        assign level_o[c*CNT_W +: CNT_W]   = count_q;
        assign overflow_o[c]               = ovf_q;
    end

endmodule

// File: tb/tb_noc_credit_valrdy_mc.sv
// Scoreboard bench for noc_credit_valrdy_mc: stimulus enqueues expected flits,
// negedge monitors pop and compare, plus directed level/overflow/credit checks.
module tb_noc_credit_valrdy_mc;

    localparam int unsigned DW  = 64;
    localparam int unsigned NC  = 3;
    localparam int unsigned CW  = 3;
    localparam int unsigned DW3 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC*DW-1:0] data_in, data_out;
    logic [NC-1:0]    valid_in, ready_out, yummy_in, valid_out, overflow_o;
    logic [NC*CW-1:0] level_o;

    logic [DW3-1:0] d3_in, d3_out;
    logic           v3_in, r3, y3, v3_out, ov3;
    logic [1:0]     lv3;

    noc_credit_valrdy_mc #(.DATA_WIDTH(DW), .DEPTH(4), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .yummy_in(yummy_in), .data_out(data_out), .valid_out(valid_out),
        .ready_out(ready_out), .level_o(level_o), .overflow_o(overflow_o)
    );

    noc_credit_valrdy_mc #(.DATA_WIDTH(DW3), .DEPTH(3), .NUM_CH(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_in(d3_in), .valid_in(v3_in),
        .yummy_in(y3), .data_out(d3_out), .valid_out(v3_out),
        .ready_out(r3), .level_o(lv3), .overflow_o(ov3)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]  exp_q [NC][$];
    logic [DW3-1:0] exp3_q [$];
    int             yum_cnt [NC];
    int             pop_cnt [NC];
    int             yum3 = 0;
    logic [NC-1:0]  pop_prev, hold_prev;
    logic [DW-1:0]  last_data [NC];
    logic           pop3_prev, hold3_prev;
    logic [DW3-1:0] last3;
    logic [DW-1:0]  mon_d, mon_e;
    logic [DW3-1:0] mon3_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] dout(input int c);
        return data_out[c*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] lvl(input int c);
        return level_o[c*CW +: CW];
    endfunction

    // Monitor for the DEPTH=4 instance.
    always @(negedge clk) begin
        for (int c = 0; c < int'(NC); c++) begin
            if (!rst_n) begin
                pop_prev[c]  = 1'b0;
                hold_prev[c] = 1'b0;
            end else begin
                mon_d = dout(c);
                check($sformatf("yummy_ch%0d", c), 64'(yummy_in[c]), 64'(pop_prev[c]));
                yum_cnt[c] += int'(yummy_in[c]);
                if (hold_prev[c]) begin
                    check($sformatf("hold_valid_ch%0d", c), 64'(valid_out[c]), 64'd1);
                    check($sformatf("hold_data_ch%0d", c), mon_d, last_data[c]);
                end
                if (!valid_out[c]) check($sformatf("zero_data_ch%0d", c), mon_d, 64'd0);
                if (valid_out[c] && ready_out[c]) begin
                    if (exp_q[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_ch%0d: got 0x%0h expected no flit", c, mon_d);
                    end else begin
                        mon_e = exp_q[c].pop_front();
                        check($sformatf("pop_data_ch%0d", c), mon_d, mon_e);
                    end
                    pop_cnt[c]++;
                end
                pop_prev[c]  = valid_out[c] && ready_out[c];
                hold_prev[c] = valid_out[c] && !ready_out[c];
                last_data[c] = mon_d;
            end
        end
    end

    // Monitor for the DEPTH=3 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pop3_prev  = 1'b0;
            hold3_prev = 1'b0;
        end else begin
            check("yummy_d3", 64'(y3), 64'(pop3_prev));
            yum3 += int'(y3);
            if (hold3_prev) check("hold_data_d3", 64'(d3_out), 64'(last3));
            if (v3_out && r3) begin
                if (exp3_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_d3: got 0x%0h expected no flit", d3_out);
                end else begin
                    mon3_e = exp3_q.pop_front();
                    check("pop_data_d3", 64'(d3_out), 64'(mon3_e));
                end
            end
            pop3_prev  = v3_out && r3;
            hold3_prev = v3_out && !r3;
            last3      = d3_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [DW-1:0] v);
        data_in[c*DW +: DW] = v;
    endtask

    int p0, y0, sent, cnt3;
    logic rr, want, pp;

    initial begin
        for (int c = 0; c < int'(NC); c++) begin
            yum_cnt[c] = 0;
            pop_cnt[c] = 0;
        end
        data_in = '0; valid_in = '0; ready_out = '0;
        d3_in = '0; v3_in = 1'b0; r3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_level", 64'(level_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_yummy", 64'(yummy_in), 64'd0);
        check("rst_data", 64'(data_out[DW-1:0]), 64'd0);
        step();
        rst_n = 1'b1;

        // Single flit on ch0.
        step();
        ready_out[0] = 1'b1; valid_in[0] = 1'b1; set_data(0, 64'hDEAD_BEEF);
        exp_q[0].push_back(64'hDEAD_BEEF);
        step();
        valid_in[0] = 1'b0;
`ifndef NOC_CRDT_VALRDY_BYPASS_EN
        check("t1_valid", 64'(valid_out[0]), 64'd1);
        check("t1_data", dout(0), 64'hDEAD_BEEF);
`endif
        step(); step();
        check("t1_level", 64'(lvl(0)), 64'd0);
        check("t1_yummies", 64'(yum_cnt[0]), 64'd1);

        // Fill ch1 with backpressure, then overflow.
        for (int k = 1; k <= 4; k++) begin
            valid_in[1] = 1'b1; set_data(1, DW'(k));
            exp_q[1].push_back(DW'(k));
            step();
        end
        valid_in[1] = 1'b0;
        check("t2_level_full", 64'(lvl(1)), 64'd4);
        check("t2_ovf_clear", 64'(overflow_o[1]), 64'd0);
        valid_in[1] = 1'b1; set_data(1, 64'd5);
        step();
        valid_in[1] = 1'b0;
        check("t2_ovf_set", 64'(overflow_o[1]), 64'd1);
        check("t2_level_hold", 64'(lvl(1)), 64'd4);
        ready_out[1] = 1'b1;
        repeat (6) step();
        check("t2_level_drained", 64'(lvl(1)), 64'd0);
        check("t2_yummies", 64'(yum_cnt[1]), 64'd4);
        check("t2_queue_empty", 64'(exp_q[1].size()), 64'd0);
        check("t2_ovf_sticky", 64'(overflow_o[1]), 64'd1);

        // Full ch2 with simultaneous push and pop.
        for (int k = 1; k <= 4; k++) begin
            valid_in[2] = 1'b1; set_data(2, DW'(k));
            exp_q[2].push_back(DW'(k));
            step();
        end
        check("t3_level_full", 64'(lvl(2)), 64'd4);
        set_data(2, 64'd5); ready_out[2] = 1'b1;
        exp_q[2].push_back(64'd5);
        step();
        valid_in[2] = 1'b0; ready_out[2] = 1'b0;
        check("t3_level_same", 64'(lvl(2)), 64'd4);
        check("t3_no_ovf", 64'(overflow_o[2]), 64'd0);
        check("t3_yummy_next", 64'(yummy_in[2]), 64'd1);
        check("t3_head", dout(2), 64'd2);
        ready_out[2] = 1'b1;
        repeat (6) step();
        check("t3_level_drained", 64'(lvl(2)), 64'd0);
        check("t3_yummies", 64'(yum_cnt[2]), 64'd5);
        ready_out[2] = 1'b0;

        // ch0 streams 100 flits while ch2 holds two flits under backpressure.
        for (int k = 0; k < 2; k++) begin
            valid_in[2] = 1'b1; set_data(2, DW'(32'hA1 + k));
            exp_q[2].push_back(DW'(32'hA1 + k));
            step();
        end
        valid_in[2] = 1'b0;
        p0 = pop_cnt[0];
        y0 = yum_cnt[0];
        for (int i = 0; i < 100; i++) begin
            valid_in[0] = 1'b1; set_data(0, DW'(1000 + i));
            exp_q[0].push_back(DW'(1000 + i));
            step();
        end
        valid_in[0] = 1'b0;
`ifndef NOC_CRDT_VALRDY_BYPASS_EN
        check("t4_throughput", 64'(pop_cnt[0] - p0), 64'd99);
`endif
        check("t4_ch2_level", 64'(lvl(2)), 64'd2);
        check("t4_ch2_head", dout(2), 64'hA1);
        repeat (3) step();
        check("t4_pops", 64'(pop_cnt[0] - p0), 64'd100);
        check("t4_yummies", 64'(yum_cnt[0] - y0), 64'd100);
        ready_out[2] = 1'b1;
        repeat (4) step();
        check("t4_ch2_drained", 64'(exp_q[2].size()), 64'd0);

        // Three flits on every channel, then asynchronous reset mid-cycle.
        ready_out = '0;
        for (int k = 0; k < 3; k++) begin
            valid_in = '1;
            for (int c = 0; c < int'(NC); c++) begin
                set_data(c, DW'(32'h300 + c * 16 + k));
                exp_q[c].push_back(DW'(32'h300 + c * 16 + k));
            end
            step();
        end
        valid_in = '0;
        check("t5_level_pre", 64'(level_o), 64'({3'd3, 3'd3, 3'd3}));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(valid_out), 64'd0);
        check("t5_level", 64'(level_o), 64'd0);
        check("t5_yummy", 64'(yummy_in), 64'd0);
        check("t5_ovf", 64'(overflow_o), 64'd0);
        check("t5_data", 64'(data_out[DW-1:0]), 64'd0);
        for (int c = 0; c < int'(NC); c++) exp_q[c].delete();
        step(); step();
        rst_n = 1'b1;
        ready_out[0] = 1'b1; valid_in[0] = 1'b1; set_data(0, 64'h55);
        exp_q[0].push_back(64'h55);
        y0 = yum_cnt[0];
        step();
        valid_in[0] = 1'b0;
        repeat (3) step();
        check("t5_post_yummy", 64'(yum_cnt[0] - y0), 64'd1);
        check("t5_post_empty", 64'(exp_q[0].size()), 64'd0);

        // DEPTH=3 instance: random bursts with random backpressure.
        sent = 0;
        cnt3 = 0;
        for (int cyc = 0; cyc < 400 && sent < 10; cyc++) begin
            rr   = 1'($urandom_range(0, 1));
            want = 1'($urandom_range(0, 1));
            pp   = (cnt3 > 0) && rr;
            r3   = rr;
            v3_in = 1'b0;
            if (want && (cnt3 < 3 || pp)) begin
                v3_in = 1'b1;
                d3_in = DW3'(16'h50 + sent);
                exp3_q.push_back(DW3'(16'h50 + sent));
                sent++;
                cnt3++;
            end
            if (pp) cnt3--;
            step();
        end
        v3_in = 1'b0;
        r3 = 1'b1;
        repeat (6) step();
        check("t6_sent", 64'(sent), 64'd10);
        check("t6_yummies", 64'(yum3), 64'd10);
        check("t6_level", 64'(lv3), 64'd0);
        check("t6_queue_empty", 64'(exp3_q.size()), 64'd0);
        check("t6_no_ovf", 64'(ov3), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
